reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width of each register.
REQ-002 SHALL provide parameter NREG, default 32, register count (power of two, 2..64); AW = log2(NREG).
REQ-003 SHALL provide parameter SNOOP_IDX, default 17, register permanently driven on snoop_data (a7 for ecall service).
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports are clk and reset_n.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 rs1_addr, rs2_addr  in  AW  read addresses.
REQ-008 rs1_data, rs2_data  out  XLEN  combinational read data.
REQ-009 wr_en  in  1  writeback strobe; wr_addr  in  AW; wr_data  in  XLEN.
REQ-010 iss_valid  in  1  instruction requesting issue; iss_rd  in  AW  destination; iss_rd_we  in  1  instruction writes rd.
REQ-011 iss_rs1_use, iss_rs2_use  in  1  instruction reads rs1/rs2 (addresses taken from rs1_addr/rs2_addr).
REQ-012 stall  out  1  combinational hazard flag; iss_fire  out  1  = iss_valid & ~stall.
REQ-013 snoop_data  out  XLEN  contents of register SNOOP_IDX; busy_cnt  out  AW+1  number of busy registers.

Function
REQ-014 Register 0 SHALL read 0 always, SHALL ignore writes, and SHALL never become busy.
REQ-015 Write: on rising clk with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data; latency 1 cycle to the array.
REQ-016 Scoreboard: one busy bit per register; on iss_fire with iss_rd_we=1 and iss_rd!=0, busy[iss_rd] set next edge.
REQ-017 On wr_en=1 with wr_addr!=0, busy[wr_addr] SHALL clear next edge, whether or not it was set.
REQ-018 Same-edge set and clear of the same register: set SHALL win (newer producer outstanding).
REQ-019 stall = iss_valid & ((iss_rs1_use & hz(rs1_addr)) | (iss_rs2_use & hz(rs2_addr)) | (iss_rd_we & hz(iss_rd))), hz(a) = busy[a] & a!=0, subject to REQ-025.
REQ-020 WAW: issue to a busy rd SHALL stall until that register's writeback.
REQ-021 busy_cnt SHALL equal the population count of busy bits, updated with them, never exceeding NREG-1.
REQ-022 Address width: addresses are AW bits; no out-of-range case exists.
REQ-023 snoop_data SHALL reflect the array (registered) value, never bypassed.

Reset
REQ-024 reset_n=0 SHALL asynchronously clear all registers to 0 and all busy bits; outputs after reset: rs1_data=rs2_data=snoop_data=0, busy_cnt=0, stall=0; reset mid-operation discards pending writes and busy state; first edge after release behaves normally.

Configuration
REQ-025 Macro REG_FILE_SB_BYPASS_EN: defined -> read port whose address equals wr_addr while wr_en=1 and wr_addr!=0 SHALL return wr_data in the same cycle, and hz(wr_addr) SHALL be 0 that cycle (writeback resolves the hazard immediately); undefined -> reads return array contents and busy[wr_addr] stalls until the edge after writeback (one extra stall cycle).

Verification
REQ-026 Reset, then wr_en=1 wr_addr=5 wr_data=0xDEADBEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF; write to addr 0 value 0x1234 -> rs2_addr=0 reads 0.
REQ-027 Issue rd=3 (iss_rd_we=1), next cycle issue with rs1_addr=3 iss_rs1_use=1 -> stall=1, iss_fire=0, busy_cnt=1; wr_en addr 3 data 7 -> with BYPASS_EN stall=0 and rs1_data=7 that cycle; without, stall=0 and rs1_data=7 the following cycle.
REQ-028 Same cycle: writeback addr 9 and iss_fire with iss_rd=9 -> after edge busy[9]=1, busy_cnt unchanged at 1, reg[9]=written data.
REQ-029 Write 2 to reg 17 -> snoop_data=2 next cycle; with BYPASS_EN snoop_data stays old value during the write cycle.
REQ-030 Issue rd=4, rd=6, writes to 10 and 11 pending, assert reset_n=0 mid-cycle -> immediately all reads 0, busy_cnt=0, stall=0; after release, reading 10 returns 0.
REQ-031 Parameter run XLEN=64 NREG=16: write 0xFFFF_FFFF_0000_0001 to reg 15, issue rd=15 twice -> second issue stalls (WAW), busy_cnt=1.

Source files
------------

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb: integer register file with issue scoreboard.
//   NREG x XLEN array, register 0 hard-wired to zero.
//   Two combinational read ports and one synchronous write (writeback) port.
//   One busy bit per register, set by issuing a producer and cleared by writeback.
//   A combinational stall flag covers RAW and WAW hazards.
//   A snoop port exposes the stored value of register SNOOP_IDX.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   rs1_addr/rs2_addr -> rs1_data/rs2_data   combinational read ports
//   wr_en, wr_addr, wr_data        writeback; also clears busy[wr_addr]
//   iss_valid, iss_rd, iss_rd_we   issue request and its destination
//   iss_rs1_use, iss_rs2_use       issue reads the rs1_addr/rs2_addr sources
//   stall, iss_fire                hazard flag, issue accepted
//   snoop_data                     stored value of register SNOOP_IDX
//   busy_cnt                       population count of the busy bits
//
// Optional feature, enabled by defining the macro REG_FILE_SB_BYPASS_EN:
//   write-to-read bypass. A writeback also resolves a hazard in the same cycle.
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter  int unsigned XLEN      = 32,
    parameter  int unsigned NREG      = 32,
    parameter  int unsigned SNOOP_IDX = 17,
    localparam int unsigned AW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_rd_we,
    input  logic            iss_rs1_use,
    input  logic            iss_rs2_use,
    output logic            stall,
    output logic            iss_fire,
    output logic [XLEN-1:0] snoop_data,
    output logic [AW:0]     busy_cnt
);

    localparam logic [AW-1:0] SNOOP_A = AW'(SNOOP_IDX);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    logic wr_act;
    logic set_act;
    logic byp1, byp2, bypd;
    logic hz1, hz2, hzd;

    // A write to register 0 is dropped entirely (no data, no busy clear)
    assign wr_act  = wr_en & (wr_addr != '0);
    assign set_act = iss_fire & iss_rd_we & (iss_rd != '0);

`ifdef REG_FILE_SB_BYPASS_EN
    assign byp1 = wr_act & (wr_addr == rs1_addr);
    assign byp2 = wr_act & (wr_addr == rs2_addr);
    assign bypd = wr_act & (wr_addr == iss_rd);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign bypd = 1'b0;
`endif

    // Read ports: register 0 reads zero; the bypass overrides the array
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        rs2_data = regs_q[rs2_addr];
        if (byp1) rs1_data = wr_data;
        if (byp2) rs2_data = wr_data;
        if (rs1_addr == '0) rs1_data = '0;
        if (rs2_addr == '0) rs2_data = '0;
    end

    // A pending writeback hides the hazard only when the bypass is present
    assign hz1 = busy_q[rs1_addr] & (rs1_addr != '0) & ~byp1;
    assign hz2 = busy_q[rs2_addr] & (rs2_addr != '0) & ~byp2;
    assign hzd = busy_q[iss_rd]   & (iss_rd   != '0) & ~bypd;

    assign stall    = iss_valid & ((iss_rs1_use & hz1) | (iss_rs2_use & hz2) | (iss_rd_we & hzd));
    assign iss_fire = iss_valid & ~stall;

    // Next busy state: clear first so that a same-edge set wins
    always_comb begin
        busy_d = busy_q;
        if (wr_act)  busy_d[wr_addr] = 1'b0;
        if (set_act) busy_d[iss_rd]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Population count of the next busy vector, registered alongside it
    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // Register array
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_act) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign snoop_data = regs_q[SNOOP_A];
    assign busy_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb: directed bench for reg_file_sb. It drives two instances:
// one with default parameters, and one with XLEN=64 and NREG=16.
// Expected values are queued as each step is driven. They are popped and
// compared once the outputs have settled, away from the clock edge.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (XLEN=32, NREG=32)
    logic        reset_n;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic [31:0] rs1_data, rs2_data, wr_data, snoop_data;
    logic        wr_en, iss_valid, iss_rd_we, iss_rs1_use, iss_rs2_use;
    logic        stall, iss_fire;
    logic [5:0]  busy_cnt;

    // Wide / small instance (XLEN=64, NREG=16)
    logic        b_reset_n;
    logic [3:0]  b_rs1_addr, b_rs2_addr, b_wr_addr, b_iss_rd;
    logic [63:0] b_rs1_data, b_rs2_data, b_wr_data, b_snoop_data;
    logic        b_wr_en, b_iss_valid, b_iss_rd_we, b_iss_rs1_use, b_iss_rs2_use;
    logic        b_stall, b_iss_fire;
    logic [4:0]  b_busy_cnt;

    reg_file_sb u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .iss_rd_we   (iss_rd_we),
        .iss_rs1_use (iss_rs1_use),
        .iss_rs2_use (iss_rs2_use),
        .stall       (stall),
        .iss_fire    (iss_fire),
        .snoop_data  (snoop_data),
        .busy_cnt    (busy_cnt)
    );

    reg_file_sb #(.XLEN(64), .NREG(16), .SNOOP_IDX(7)) u_dut64 (
        .clk         (clk),
        .reset_n     (b_reset_n),
        .rs1_addr    (b_rs1_addr),
        .rs2_addr    (b_rs2_addr),
        .rs1_data    (b_rs1_data),
        .rs2_data    (b_rs2_data),
        .wr_en       (b_wr_en),
        .wr_addr     (b_wr_addr),
        .wr_data     (b_wr_data),
        .iss_valid   (b_iss_valid),
        .iss_rd      (b_iss_rd),
        .iss_rd_we   (b_iss_rd_we),
        .iss_rs1_use (b_iss_rs1_use),
        .iss_rs2_use (b_iss_rs2_use),
        .stall       (b_stall),
        .iss_fire    (b_iss_fire),
        .snoop_data  (b_snoop_data),
        .busy_cnt    (b_busy_cnt)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL sb_empty: observed %0h, nothing expected", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; b_reset_n = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd17; wr_addr = '0; iss_rd = '0; wr_data = '0;
        wr_en = 1'b0; iss_valid = 1'b0; iss_rd_we = 1'b0; iss_rs1_use = 1'b0; iss_rs2_use = 1'b0;
        b_rs1_addr = '0; b_rs2_addr = '0; b_wr_addr = '0; b_iss_rd = '0; b_wr_data = '0;
        b_wr_en = 1'b0; b_iss_valid = 1'b0; b_iss_rd_we = 1'b0; b_iss_rs1_use = 1'b0; b_iss_rs2_use = 1'b0;

        // Outputs while held in reset
        repeat (2) @(posedge clk);
        #1;
        exp("rst_rs1", 64'd0); exp("rst_rs2", 64'd0); exp("rst_snoop", 64'd0);
        exp("rst_cnt", 64'd0); exp("rst_stall", 64'd0);
        #1;
        chk(64'(rs1_data)); chk(64'(rs2_data)); chk(64'(snoop_data));
        chk(64'(busy_cnt)); chk(64'(stall));
        reset_n = 1'b1; b_reset_n = 1'b1;
        tick();

        // Write reg 5, read it back on the next cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0; rs1_addr = 5'd5;
        exp("rd5", 64'hDEADBEEF);
        #1; chk(64'(rs1_data));

        // A write to reg 0 is ignored
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs2_addr = 5'd0;
        tick();
        wr_en = 1'b0;
        exp("rd0", 64'd0); exp("w0_cnt", 64'd0);
        #1; chk(64'(rs2_data)); chk(64'(busy_cnt));

        // Issue a producer of rd=3
        iss_valid = 1'b1; iss_rd = 5'd3; iss_rd_we = 1'b1;
        exp("iss3_fire", 64'd1); exp("iss3_stall", 64'd0);
        #1; chk(64'(iss_fire)); chk(64'(stall));
        tick();

        // A consumer of reg 3 stalls (RAW)
        iss_rd_we = 1'b0; iss_rd = 5'd0; iss_rs1_use = 1'b1; rs1_addr = 5'd3;
        exp("raw_stall", 64'd1); exp("raw_fire", 64'd0); exp("raw_cnt", 64'd1);
        #1; chk(64'(stall)); chk(64'(iss_fire)); chk(64'(busy_cnt));

        // Writeback of reg 3 arrives while the consumer waits
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
`ifdef REG_FILE_SB_BYPASS_EN
        exp("wb_stall", 64'd0); exp("wb_rs1", 64'd7);
`else
        exp("wb_stall", 64'd1); exp("wb_rs1", 64'd0);
`endif
        #1; chk(64'(stall)); chk(64'(rs1_data));
        tick();
        wr_en = 1'b0;
        exp("post_wb_stall", 64'd0); exp("post_wb_rs1", 64'd7); exp("post_wb_cnt", 64'd0);
        #1; chk(64'(stall)); chk(64'(rs1_data)); chk(64'(busy_cnt));
        iss_valid = 1'b0; iss_rs1_use = 1'b0;
        tick();

        // Issue to rd=0 fires but never makes reg 0 busy
        iss_valid = 1'b1; iss_rd = 5'd0; iss_rd_we = 1'b1;
        exp("rdz_fire", 64'd1);
        #1; chk(64'(iss_fire));
        tick();
        iss_valid = 1'b0; iss_rd_we = 1'b0;
        exp("rdz_cnt", 64'd0);
        #1; chk(64'(busy_cnt));

        // Same-edge set and clear of reg 9: the set wins
`ifdef REG_FILE_SB_BYPASS_EN
        iss_valid = 1'b1; iss_rd = 5'd9; iss_rd_we = 1'b1;
        tick();
        exp("pre_setclr_cnt", 64'd1);
        #1; chk(64'(busy_cnt));
`endif
        iss_valid = 1'b1; iss_rd = 5'd9; iss_rd_we = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        exp("setclr_fire", 64'd1);
        #1; chk(64'(iss_fire));
        tick();
        iss_valid = 1'b0; iss_rd_we = 1'b0; wr_en = 1'b0; rs1_addr = 5'd9;
        exp("setclr_cnt", 64'd1); exp("setclr_reg9", 64'h99);
        #1; chk(64'(busy_cnt)); chk(64'(rs1_data));
        iss_valid = 1'b1; iss_rs1_use = 1'b1;
        exp("setclr_busy9", 64'd1);
        #1; chk(64'(stall));
        iss_valid = 1'b0; iss_rs1_use = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        wr_en = 1'b0;
        exp("clr9_cnt", 64'd0);
        #1; chk(64'(busy_cnt));

        // The snoop port shows the stored value only
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'd2;
        exp("snoop_old", 64'd0);
        #1; chk(64'(snoop_data));
        tick();
        wr_en = 1'b0;
        exp("snoop_new", 64'd2);
        #1; chk(64'(snoop_data));

        // Build busy state and a pending write, then reset mid-cycle
        iss_valid = 1'b1; iss_rd = 5'd4; iss_rd_we = 1'b1;
        tick();
        iss_rd = 5'd6;
        tick();
        iss_rd = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAA;
        rs1_addr = 5'd5; rs2_addr = 5'd17;
        exp("pre_rst_cnt", 64'd2); exp("pre_rst_stall", 64'd1); exp("pre_rst_rs1", 64'hDEADBEEF);
        #1; chk(64'(busy_cnt)); chk(64'(stall)); chk(64'(rs1_data));
        #1;
        reset_n = 1'b0;
        exp("mid_rst_rs1", 64'd0); exp("mid_rst_rs2", 64'd0); exp("mid_rst_snoop", 64'd0);
        exp("mid_rst_cnt", 64'd0); exp("mid_rst_stall", 64'd0);
        #1; chk(64'(rs1_data)); chk(64'(rs2_data)); chk(64'(snoop_data));
        chk(64'(busy_cnt)); chk(64'(stall));
        tick();
        wr_en = 1'b0; iss_valid = 1'b0; iss_rd_we = 1'b0;
        reset_n = 1'b1;
        tick();
        rs1_addr = 5'd10;
        exp("post_rst_r10", 64'd0);
        #1; chk(64'(rs1_data));

        // The first edges after release behave normally
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        exp("post_rst_w10", 64'h55);
        #1; chk(64'(rs1_data));

        // 64-bit, 16-register instance: wide data and a WAW stall
        b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'hFFFF_FFFF_0000_0001;
        tick();
        b_wr_en = 1'b0; b_rs1_addr = 4'd15;
        exp("w64_rd15", 64'hFFFF_FFFF_0000_0001);
        #1; chk(b_rs1_data);
        b_iss_valid = 1'b1; b_iss_rd = 4'd15; b_iss_rd_we = 1'b1;
        exp("w64_iss1_fire", 64'd1);
        #1; chk(64'(b_iss_fire));
        tick();
        exp("waw_stall", 64'd1); exp("waw_fire", 64'd0); exp("waw_cnt", 64'd1);
        #1; chk(64'(b_stall)); chk(64'(b_iss_fire)); chk(64'(b_busy_cnt));
        b_iss_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
